mprj2_logic_seq: RTL

Parametrised, sequenced tie-off generator for the user-project area 2 (vccd2/vssd2) domain. It drives NCH complementary tie pairs (hi_o/lo_o). During reset, and on request, every channel is held in its safe state. When released, channels come up one at a time, with a programmable stagger, so user-area-2 logic and enables do not all switch on at once. It sits at the management/user-area-2 boundary in place of fixed constant tie cells.

---
 rtl/mprj2_logic_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mprj2_logic_seq.sv
// -----------------------------------------------------------------------------
// mprj2_logic_seq
//   Sequenced tie-off generator for the user-project area 2 domain. Drives NCH
//   complementary tie pairs (hi_o / lo_o). While reset or hold_i is asserted
//   every channel sits in its safe state (hi=0, lo=1). On release, channels
//   are brought up one per stage of STAGE_CYC clocks, lowest index first, so
//   the user area does not see every enable switch on in the same cycle.
//
// Ports
//   vccd2, vssd2  inout   power pins (only with USE_POWER_PINS)
//   clock         input   single clock, rising edge
//   resetn        input   asynchronous active-low reset
//   hold_i        input   1 = force all channels back to held state
//   mask_i[NCH]   input   per-channel enable, captured when a ramp starts
//   hi_o[NCH]     output  tie-high per channel (0 = held, 1 = released)
//   lo_o[NCH]     output  always ~hi_o
//   busy_o        output  1 while channels are being released
//   done_o        output  1 once every stage has completed
// -----------------------------------------------------------------------------
module mprj2_logic_seq #(
    parameter int NCH       = 8,
    parameter int STAGE_CYC = 4,
    parameter int CW        = $clog2(STAGE_CYC) + 1
) (
`ifdef USE_POWER_PINS
    inout  wire             vccd2,
    inout  wire             vssd2,
`endif
    input  logic            clock,
    input  logic            resetn,
    input  logic            hold_i,
    input  logic [NCH-1:0]  mask_i,
    output logic [NCH-1:0]  hi_o,
    output logic [NCH-1:0]  lo_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int CHW = $clog2(NCH) + 1;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_reg,  state_next;
    logic [CW-1:0]    cnt_reg,    cnt_next;
    logic [CHW-1:0]   ch_reg,     ch_next;
    logic [NCH-1:0]   mask_q_reg, mask_q_next;
    logic [NCH-1:0]   hi_q_reg,   hi_q_next;

    logic             stage_end;
    logic             last_ch;
    logic [NCH-1:0]   ch_sel;

    assign stage_end = (cnt_reg == CW'(STAGE_CYC - 1));
    assign last_ch   = (ch_reg == CHW'(NCH - 1));

    // One-hot decode of the channel currently being released; avoids indexing
    // hi/mask with a counter that is one bit wider than the channel index.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_sel
            assign ch_sel[gi] = (ch_reg == CHW'(gi));
        end
    endgenerate

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= ST_HOLD;
            cnt_reg    <= '0;
            ch_reg     <= '0;
            mask_q_reg <= '0;
            hi_q_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            ch_reg     <= ch_next;
            mask_q_reg <= mask_q_next;
            hi_q_reg   <= hi_q_next;
        end
    end

    // Next-state and datapath logic. hold_i is checked first in every state so
    // that a hold always wins over a stage release in the same cycle.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        ch_next     = ch_reg;
        mask_q_next = mask_q_reg;
        hi_q_next   = hi_q_reg;
        case (state_reg)
            ST_HOLD: begin
                hi_q_next = '0;
                if (!hold_i) begin
                    state_next  = ST_RAMP;
                    cnt_next    = '0;
                    ch_next     = '0;
                    mask_q_next = mask_i;
                end
            end
            ST_RAMP: begin
                if (hold_i) begin
                    state_next = ST_HOLD;
                    hi_q_next  = '0;
                end else if (stage_end) begin
                    // Masked-off channels still use their stage, they just
                    // stay at 0.
                    hi_q_next = (hi_q_reg & ~ch_sel) | (mask_q_reg & ch_sel);
                    cnt_next  = '0;
                    ch_next   = ch_reg + CHW'(1);
                    if (last_ch) begin
                        state_next = ST_DONE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_DONE: begin
                if (hold_i) begin
                    state_next = ST_HOLD;
                    hi_q_next  = '0;
                end
            end
            default: begin
                state_next = ST_HOLD;
                hi_q_next  = '0;
            end
        endcase
    end

    // Outputs: all derived directly from registers.
    always_comb begin
        hi_o   = hi_q_reg;
        lo_o   = ~hi_q_reg;
        busy_o = (state_reg == ST_RAMP);
        done_o = (state_reg == ST_DONE);
    end

endmodule
